mario_tile_query_arbiter: RTL

- Shared tile-lookup server for the background map: up to NUM_REQ movers (horizontal mover, vertical/gravity mover, enemy mover) request the tile code under a pixel coordinate.
- Arbitrates round-robin, converts pixel to tile indices, reads the 12x17 background array and returns the code plus a solid flag through a req/ack handshake.
- Sits between the movement FSMs and the background map and runs on movement_clock.

---
 rtl/mario_tile_query_arbiter_if.sv | 23 ++
 rtl/mario_tile_query_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mario_tile_query_arbiter_if.sv
// Request/response bundle between the movement FSMs and the tile-query arbiter.
interface mario_tile_query_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]  req;
    logic signed [31:0]  req_x [NUM_REQ];
    logic signed [31:0]  req_y [NUM_REQ];
    logic [NUM_REQ-1:0]  ack;
    logic [1:0]          grant_id;
    logic [7:0]          tile_code;
    logic                tile_solid;
    logic                busy;

    modport master (
        output req, req_x, req_y,
        input  ack, grant_id, tile_code, tile_solid, busy
    );

    modport slave (
        input  req, req_x, req_y,
        output ack, grant_id, tile_code, tile_solid, busy
    );
endinterface

// File: rtl/mario_tile_query_arbiter.sv
// Shared background-tile lookup server: round-robin arbitration among movers,
// pixel-to-tile conversion and a one-cycle ack carrying the tile code and solid flag.
module mario_tile_query_arbiter #(
    parameter int         NUM_REQ       = 3,
    parameter logic [7:0] BDR           = 8'd0,
    parameter logic [7:0] SKY           = 8'd1,
    parameter logic [7:0] BLK           = 8'd2,
    parameter logic [7:0] GND           = 8'd3,
    parameter int         SCREEN_WIDTH  = 640,
    parameter int         SCREEN_HEIGHT = 480,
    parameter int         BLOCK_WIDTH   = 40
) (
    input  logic                    movement_clock,
    input  logic                    reset,
    input  logic [11:0][16:0][7:0]  background,
    mario_tile_query_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LOOKUP, RESPOND} state_t;

    state_t             state_q, state_d;
    logic [1:0]         grant_q, grant_d;
    logic [1:0]         last_grant_q, last_grant_d;
    logic signed [31:0] lat_x_q, lat_x_d;
    logic signed [31:0] lat_y_q, lat_y_d;
    logic [7:0]         tile_code_q, tile_code_d;
    logic               tile_solid_q, tile_solid_d;
    logic [1:0]         winner;
    logic [1:0]         rr_idx;
    logic               found;
    logic [7:0]         lookup_code;

    // Off-screen coordinates and anything outside the 12x17 map read as border.
    function automatic logic [7:0] map_lookup(input logic signed [31:0] x,
                                              input logic signed [31:0] y,
                                              input logic [11:0][16:0][7:0] map);
        logic signed [31:0] row;
        logic signed [31:0] col;
        logic [7:0]         code;
        code = BDR;
        row  = '0;
        col  = '0;
        if (x >= 0 && x < SCREEN_WIDTH && y >= 0 && y < SCREEN_HEIGHT) begin
            col = x / BLOCK_WIDTH;
            row = y / BLOCK_WIDTH;
            if (row <= 11 && col <= 16) begin
                code = map[row[3:0]][col[4:0]];
            end
        end
        return code;
    endfunction

    function automatic logic is_solid(input logic [7:0] code);
        return (code == BLK) || (code == GND) || (code == BDR);
    endfunction

    assign lookup_code = map_lookup(lat_x_q, lat_y_q, background);

    // Round-robin search starting just after the last served requester.
    always_comb begin
        winner = last_grant_q;
        found  = 1'b0;
        rr_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_idx = 2'((int'(last_grant_q) + k) % NUM_REQ);
            if (!found && bus.req[rr_idx]) begin
                winner = rr_idx;
                found  = 1'b1;
            end
        end
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge movement_clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one cycle each for grant, lookup and response.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (found) state_d = LOOKUP;
            LOOKUP:  state_d = RESPOND;
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the current state; ack only while responding.
    always_comb begin
        bus.ack  = '0;
        bus.busy = (state_q != IDLE);
        if (state_q == RESPOND) begin
            bus.ack[grant_q] = 1'b1;
        end
    end

    assign bus.grant_id   = grant_q;
    assign bus.tile_code  = tile_code_q;
    assign bus.tile_solid = tile_solid_q;

    // Datapath next values: capture at grant, look up once, remember the winner on response.
    always_comb begin
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        lat_x_d      = lat_x_q;
        lat_y_d      = lat_y_q;
        tile_code_d  = tile_code_q;
        tile_solid_d = tile_solid_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = winner;
                    lat_x_d = bus.req_x[winner];
                    lat_y_d = bus.req_y[winner];
                end
            end
            LOOKUP: begin
                tile_code_d  = lookup_code;
                tile_solid_d = is_solid(lookup_code);
            end
            RESPOND: last_grant_d = grant_q;
            default: ;
        endcase
    end

    // Control and result registers with their reset values.
    always_ff @(posedge movement_clock or negedge reset) begin
        if (!reset) begin
            grant_q      <= '0;
            last_grant_q <= 2'(NUM_REQ - 1);
            tile_code_q  <= SKY;
            tile_solid_q <= 1'b0;
        end else begin
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            tile_code_q  <= tile_code_d;
            tile_solid_q <= tile_solid_d;
        end
    end

    // Latched coordinates are pure data and need no reset.
    always_ff @(posedge movement_clock) begin
        lat_x_q <= lat_x_d;
        lat_y_q <= lat_y_d;
    end

endmodule
